// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the 2-way set-associative read cache.
package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG_CHECK,
        S_MISS_REQ,
        S_REFILL,
        S_RESPOND,
        S_FLUSH
    } state_e;

    function automatic int offset_w(input int words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int index_w(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_w(input int addr_w, input int words_per_block, input int num_sets);
        return addr_w - $clog2(words_per_block) - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: tag and data arrays (not reset) plus a resettable valid flop array.
module cache_way
    import cache_pkg::*;
#(
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_SETS        = 256,
    parameter int TAG_W           = 6
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [index_w(NUM_SETS)-1:0]          rd_idx_i,
    input  logic [offset_w(WORDS_PER_BLOCK)-1:0]  rd_off_i,
    output logic                                  rd_valid_o,
    output logic [TAG_W-1:0]                      rd_tag_o,
    output logic [WORD_W-1:0]                     rd_word_o,
    input  logic                                  wr_en_i,
    input  logic [index_w(NUM_SETS)-1:0]          wr_idx_i,
    input  logic [offset_w(WORDS_PER_BLOCK)-1:0]  wr_off_i,
    input  logic [WORD_W-1:0]                     wr_data_i,
    input  logic                                  tag_we_i,
    input  logic [TAG_W-1:0]                      tag_i,
    input  logic                                  inv_en_i,
    input  logic [index_w(NUM_SETS)-1:0]          inv_idx_i
);
    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [WORD_W-1:0]   data_q [NUM_SETS][WORDS_PER_BLOCK];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            if (inv_en_i) valid_q[inv_idx_i] <= 1'b0;
            if (tag_we_i) valid_q[wr_idx_i]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we_i) tag_q[wr_idx_i] <= tag_i;
        if (wr_en_i)  data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_word_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/cache_2way_ctrl.sv
// 2-way set-associative read cache controller: LRU replacement, burst refill, flush FSM.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_2way_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W          = 16,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_SETS        = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_data,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [WORD_W-1:0] mem_resp_data
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int OFFSET_W = offset_w(WORDS_PER_BLOCK);
    localparam int INDEX_W  = index_w(NUM_SETS);
    localparam int TAG_W    = tag_w(ADDR_W, WORDS_PER_BLOCK, NUM_SETS);

    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]  idx_t;
    typedef logic [OFFSET_W-1:0] off_t;

    localparam off_t LAST_BEAT = off_t'(WORDS_PER_BLOCK - 1);
    localparam idx_t LAST_IDX  = idx_t'(NUM_SETS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, mem_req_addr_q;
    logic                rdy_q, victim_q, hit_pend_q, resp_valid_q;
    logic [WORD_W-1:0]   resp_data_q, hit_word_q, cap_q;
    off_t                beat_q;
    idx_t                flush_idx_q, inv_idx;
    logic [NUM_SETS-1:0] lru_q;

    logic [1:0]              way_v, way_we, way_tag_we, way_inv;
    logic [1:0][TAG_W-1:0]   way_tag;
    logic [1:0][WORD_W-1:0]  way_word;

    off_t off_a;
    idx_t idx_a;
    tag_t tag_a;
    logic hit, hit_way, victim;
    logic [WORD_W-1:0] hit_word;

    assign off_a = addr_q[OFFSET_W-1:0];
    assign idx_a = addr_q[OFFSET_W +: INDEX_W];
    assign tag_a = addr_q[ADDR_W-1 -: TAG_W];

    assign hit      = (way_v[0] && way_tag[0] == tag_a) || (way_v[1] && way_tag[1] == tag_a);
    assign hit_way  = way_v[1] && way_tag[1] == tag_a;
    assign hit_word = hit_way ? way_word[1] : way_word[0];
    // Fill an empty way before evicting anything; way0 wins when both are empty.
    assign victim   = !way_v[0] ? 1'b0 : (!way_v[1] ? 1'b1 : lru_q[idx_a]);

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way #(
            .WORD_W(WORD_W), .WORDS_PER_BLOCK(WORDS_PER_BLOCK),
            .NUM_SETS(NUM_SETS), .TAG_W(TAG_W)
        ) u_way (
            .clk(clk), .rst(rst),
            .rd_idx_i(idx_a), .rd_off_i(off_a),
            .rd_valid_o(way_v[w]), .rd_tag_o(way_tag[w]), .rd_word_o(way_word[w]),
            .wr_en_i(way_we[w]), .wr_idx_i(idx_a), .wr_off_i(beat_q), .wr_data_i(mem_resp_data),
            .tag_we_i(way_tag_we[w]), .tag_i(tag_a),
            .inv_en_i(way_inv[w]), .inv_idx_i(inv_idx)
        );
    end

    always_comb begin
        state_d    = state_q;
        way_we     = '0;
        way_tag_we = '0;
        way_inv    = '0;
        inv_idx    = idx_a;
        unique case (state_q)
            S_IDLE: begin
                if (flush)                  state_d = S_FLUSH;
                else if (req_valid && rdy_q) state_d = S_TAG_CHECK;
            end
            S_TAG_CHECK: state_d = hit ? S_IDLE : S_MISS_REQ;
            S_MISS_REQ: begin
                if (mem_req_ready) begin
                    state_d          = S_REFILL;
                    way_inv[victim_q] = 1'b1;
                end
            end
            S_REFILL: begin
                if (mem_resp_valid) begin
                    way_we[victim_q]     = 1'b1;
                    way_tag_we[victim_q] = (beat_q == LAST_BEAT);
                    if (beat_q == LAST_BEAT) state_d = S_RESPOND;
                end
            end
            S_RESPOND: state_d = S_IDLE;
            S_FLUSH: begin
                way_inv = '1;
                inv_idx = flush_idx_q;
                if (flush_idx_q == LAST_IDX) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            rdy_q          <= 1'b0;
            addr_q         <= '0;
            mem_req_addr_q <= '0;
            victim_q       <= 1'b0;
            hit_pend_q     <= 1'b0;
            hit_word_q     <= '0;
            cap_q          <= '0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            beat_q         <= '0;
            flush_idx_q    <= '0;
            lru_q          <= '0;
        end else begin
            state_q      <= state_d;
            rdy_q        <= (state_d == S_IDLE);
            hit_pend_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            // Hits take one extra registered stage so the response lands two edges after acceptance.
            if (hit_pend_q) begin
                resp_valid_q <= 1'b1;
                resp_data_q  <= hit_word_q;
            end
            unique case (state_q)
                S_IDLE: if (!flush && req_valid && rdy_q) addr_q <= req_addr;
                S_TAG_CHECK: begin
                    if (hit) begin
                        hit_pend_q     <= 1'b1;
                        hit_word_q     <= hit_word;
                        lru_q[idx_a]   <= ~hit_way;
                    end else begin
                        victim_q       <= victim;
                        mem_req_addr_q <= {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    end
                end
                S_REFILL: begin
                    if (mem_resp_valid) begin
                        if (beat_q == off_a) cap_q <= mem_resp_data;
                        if (beat_q == LAST_BEAT) begin
                            beat_q       <= '0;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= (off_a == LAST_BEAT) ? mem_resp_data : cap_q;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                S_RESPOND: lru_q[idx_a] <= ~victim_q;
                S_FLUSH: begin
                    lru_q[flush_idx_q] <= 1'b0;
                    flush_idx_q        <= flush_idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_TAG_CHECK) begin
            if (hit && hit_cnt_q != '1)       hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (!hit && miss_cnt_q != '1)     miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    assign req_ready     = rdy_q;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign mem_req_valid = (state_q == S_MISS_REQ);
    assign mem_req_addr  = mem_req_addr_q;

endmodule

// File: tb/tb_cache_2way_ctrl.sv
// Directed self-checking bench for cache_2way_ctrl at default geometry (tag 6b, index 8b, offset 2b).
module tb_cache_2way_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [15:0] req_addr = '0;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        flush = 1'b0;
    logic        mem_req_valid, mem_req_ready = 1'b0;
    logic [15:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_2way_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic [15:0] a, output bit ok);
        int n = 0;
        while (!req_ready && n < 300) begin tick(); n++; end
        ok = req_ready;
        if (ok) begin
            req_valid = 1'b1; req_addr = a;
            tick();
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_resp(input int maxc, output bit seen, output logic [31:0] d, output int cyc);
        seen = 1'b0; d = '0; cyc = 0;
        while (!seen && cyc < maxc) begin
            tick(); cyc++;
            if (resp_valid) begin seen = 1'b1; d = resp_data; end
        end
    endtask

    task automatic serve_miss(input logic [31:0] base, output bit got, output logic [15:0] maddr,
                              output logic rv, output logic [31:0] rd);
        int n = 0;
        got = 1'b0; maddr = '0; rv = 1'b0; rd = '0;
        while (!mem_req_valid && n < 20) begin tick(); n++; end
        if (mem_req_valid) begin
            got = 1'b1; maddr = mem_req_addr;
            mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
            for (int k = 0; k < 4; k++) begin
                mem_resp_valid = 1'b1; mem_resp_data = base + 32'(k);
                tick();
            end
            mem_resp_valid = 1'b0;
            rv = resp_valid; rd = resp_data;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_data !== 32'h0) begin failures++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid); end
        checks++; if (mem_req_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_req_addr: got %h want 0", mem_req_addr); end
        rst = 1'b1;
        tick();
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_cold_miss();
        bit ok, got, seen; logic [15:0] ma; logic rv; logic [31:0] rd; int cyc;
        issue_req(16'h0123, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL cold_accept: got %b want 1", ok); end
        serve_miss(32'hA0, got, ma, rv, rd);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL cold_mem_req: got %b want 1", got); end
        checks++; if (ma !== 16'h0120) begin failures++; $display("FAIL cold_mem_addr: got %h want 0120", ma); end
        checks++; if (rv !== 1'b1 || rd !== 32'hA3) begin failures++; $display("FAIL cold_resp: got v=%b d=%h want v=1 d=a3", rv, rd); end
        tick();
        checks++; if (resp_valid !== 1'b0 || resp_data !== 32'hA3) begin failures++; $display("FAIL cold_resp_pulse_hold: got v=%b d=%h want v=0 d=a3", resp_valid, resp_data); end
        issue_req(16'h0121, ok);
        wait_resp(4, seen, rd, cyc);
        checks++; if (!ok || !seen || rd !== 32'hA1) begin failures++; $display("FAIL hit_0121: got seen=%b d=%h want seen=1 d=a1", seen, rd); end
        checks++; if (cyc !== 2) begin failures++; $display("FAIL hit_latency: got %0d edges want 2", cyc); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL hit_no_mem_req: got %b want 0", mem_req_valid); end
`ifdef CACHE_STATS_EN
        checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin failures++; $display("FAIL stats_cold: got h=%0d m=%0d want h=1 m=1", hit_count, miss_count); end
`endif
    endtask

    task automatic test_lru();
        bit ok, got, seen; logic [15:0] ma; logic rv; logic [31:0] rd; int cyc;
        issue_req(16'h0523, ok);
        serve_miss(32'hB0, got, ma, rv, rd);
        checks++; if (!ok || !got || ma !== 16'h0520 || rd !== 32'hB3) begin failures++; $display("FAIL lru_fill_0523: got req=%b a=%h d=%h want req=1 a=0520 d=b3", got, ma, rd); end
        issue_req(16'h0123, ok);
        wait_resp(4, seen, rd, cyc);
        checks++; if (!ok || !seen || rd !== 32'hA3) begin failures++; $display("FAIL lru_hit_0123: got seen=%b d=%h want seen=1 d=a3", seen, rd); end
        issue_req(16'h0923, ok);
        serve_miss(32'hC0, got, ma, rv, rd);
        checks++; if (!ok || !got || rv !== 1'b1 || rd !== 32'hC3) begin failures++; $display("FAIL lru_miss_0923: got req=%b v=%b d=%h want req=1 v=1 d=c3", got, rv, rd); end
        issue_req(16'h0123, ok);
        wait_resp(4, seen, rd, cyc);
        checks++; if (!ok || !seen || rd !== 32'hA3 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL lru_keep_0123: got seen=%b d=%h want seen=1 d=a3", seen, rd); end
        issue_req(16'h0523, ok);
        serve_miss(32'hD0, got, ma, rv, rd);
        checks++; if (!ok || !got || ma !== 16'h0520 || rd !== 32'hD3) begin failures++; $display("FAIL lru_evicted_0523: got req=%b a=%h d=%h want req=1 a=0520 d=d3", got, ma, rd); end
    endtask

    task automatic test_flush();
        bit ok, got, stray; logic [15:0] ma; logic rv; logic [31:0] rd; int cnt;
        int n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        flush = 1'b1; req_valid = 1'b1; req_addr = 16'h0123;
        tick();
        flush = 1'b0; req_valid = 1'b0;
        cnt = 0; stray = 1'b0;
        while (!req_ready && cnt < 400) begin
            if (resp_valid || mem_req_valid) stray = 1'b1;
            tick(); cnt++;
        end
        checks++; if (cnt !== 256) begin failures++; $display("FAIL flush_ready_low: got %0d cycles want 256", cnt); end
        checks++; if (stray !== 1'b0) begin failures++; $display("FAIL flush_req_accepted: got activity=%b want 0", stray); end
`ifdef CACHE_STATS_EN
        checks++; if (hit_count !== 32'd3 || miss_count !== 32'd4) begin failures++; $display("FAIL stats_flush: got h=%0d m=%0d want h=3 m=4", hit_count, miss_count); end
`endif
        issue_req(16'h0123, ok);
        serve_miss(32'hE0, got, ma, rv, rd);
        checks++; if (!ok || !got || ma !== 16'h0120 || rd !== 32'hE3) begin failures++; $display("FAIL flush_then_miss: got req=%b a=%h d=%h want req=1 a=0120 d=e3", got, ma, rd); end
    endtask

    task automatic test_backpressure();
        bit ok, seen; logic [31:0] rd; int cyc, bad, n;
        issue_req(16'h0200, ok);
        n = 0;
        while (!mem_req_valid && n < 20) begin tick(); n++; end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD; end
            tick();
            mem_resp_valid = 1'b0;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 16'h0200 || resp_valid) bad++;
        end
        checks++; if (!ok || bad !== 0) begin failures++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hF0 + 32'(k);
            tick();
        end
        mem_resp_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_data !== 32'hF0) begin failures++; $display("FAIL bp_resp: got v=%b d=%h want v=1 d=f0", resp_valid, resp_data); end
        issue_req(16'h0203, ok);
        wait_resp(4, seen, rd, cyc);
        checks++; if (!ok || !seen || rd !== 32'hF3) begin failures++; $display("FAIL bp_line_order: got seen=%b d=%h want seen=1 d=f3", seen, rd); end
    endtask

    task automatic test_reset_refill();
        bit ok, got, stray; logic [15:0] ma; logic rv; logic [31:0] rd; int n;
        issue_req(16'h0300, ok);
        n = 0;
        while (!mem_req_valid && n < 20) begin tick(); n++; end
        mem_req_ready = 1'b1; tick(); mem_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'h10 + 32'(k);
            tick();
        end
        rst = 1'b0; mem_resp_data = 32'h12;
        tick();
        stray = resp_valid;
        checks++; if (req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_state: got rdy=%b mreq=%b want 0 0", req_ready, mem_req_valid); end
        rst = 1'b1; mem_resp_data = 32'h13;
        tick();
        stray = stray | resp_valid;
        mem_resp_valid = 1'b0;
        tick();
        stray = stray | resp_valid;
        checks++; if (stray !== 1'b0) begin failures++; $display("FAIL rst_mid_no_resp: got %b want 0", stray); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_idle: got rdy=%b want 1", req_ready); end
        issue_req(16'h0302, ok);
        serve_miss(32'h20, got, ma, rv, rd);
        checks++; if (!ok || !got || ma !== 16'h0300 || rv !== 1'b1 || rd !== 32'h22) begin failures++; $display("FAIL rst_mid_rerefill: got req=%b a=%h v=%b d=%h want req=1 a=0300 v=1 d=22", got, ma, rv, rd); end
`ifdef CACHE_STATS_EN
        checks++; if (hit_count !== 32'd0 || miss_count !== 32'd1) begin failures++; $display("FAIL stats_after_rst: got h=%0d m=%0d want h=0 m=1", hit_count, miss_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_lru();
        test_flush();
        test_backpressure();
        test_reset_refill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
